// File: rtl/spi_sprite_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_sprite_loader_if
// Purpose  : SPI pin bundle between an SPI master and the sprite loader.
//            spi_miso exists only when SPI_LOADER_MISO_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_sprite_loader_if;
  logic spi_clk;
  logic spi_data;
  logic spi_sel_n;
`ifdef SPI_LOADER_MISO_EN
  logic spi_miso;

  modport master (output spi_clk, output spi_data, output spi_sel_n, input  spi_miso);
  modport slave  (input  spi_clk, input  spi_data, input  spi_sel_n, output spi_miso);
`else
  modport master (output spi_clk, output spi_data, output spi_sel_n);
  modport slave  (input  spi_clk, input  spi_data, input  spi_sel_n);
`endif
endinterface
`default_nettype wire

// File: rtl/spi_sprite_loader.sv
`default_nettype none
// ============================================================================
// Module   : spi_sprite_loader
// Purpose  : Mode-0 SPI slave feeding the sprite shift register and providing
//            frame-synchronous background/sprite colour registers.
//            Optional feature macro: SPI_LOADER_MISO_EN (echo of the previous
//            command byte on spi_miso while a command byte is received).
// Revision : 1.0 - initial release
// ============================================================================
module spi_sprite_loader #(
  parameter int         SPRITE_BITS = 100,
  parameter logic [5:0] BG_RESET    = 6'b010101,
  parameter logic [5:0] FG_RESET    = 6'b111111
) (
  input  logic               clk,
  input  logic               reset,
  spi_sprite_loader_if.slave spi,
  input  logic               next_frame,
  output logic               sprite_load,
  output logic               sprite_data,
  output logic               load_done,
  output logic               cmd_error,
  output logic [5:0]         bg_color,
  output logic [5:0]         fg_color
);

  // Counter must hold both a byte index (0..7) and a bitmap index.
  localparam int CNT_W = ($clog2(SPRITE_BITS) > 3) ? $clog2(SPRITE_BITS) : 3;
  localparam logic [CNT_W-1:0] BYTE_LAST   = CNT_W'(7);
  localparam logic [CNT_W-1:0] SPRITE_LAST = CNT_W'(SPRITE_BITS - 1);

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_BG   = 8'h02;
  localparam logic [7:0] CMD_FG   = 8'h03;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_LOAD, S_ARG, S_DISCARD} state_t;

  // Synchroniser chains: [1] is the synchronised value, [2] its previous value.
  logic [2:0] sclk_sync_d, sclk_sync_q;
  logic [2:0] sel_sync_d,  sel_sync_q;
  logic [1:0] data_sync_d, data_sync_q;

  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [6:0]       shift_d, shift_q;
  logic             target_bg_d, target_bg_q;
  logic [5:0]       bg_shadow_d, bg_shadow_q;
  logic [5:0]       fg_shadow_d, fg_shadow_q;
  logic             pending_d, pending_q;
  logic [5:0]       bg_color_d, bg_color_q;
  logic [5:0]       fg_color_d, fg_color_q;
  logic             sprite_load_d, sprite_load_q;
  logic             sprite_data_d, sprite_data_q;
  logic             load_done_d, load_done_q;
  logic             cmd_error_d, cmd_error_q;

  logic       sclk_s, sclk_q, sel_s, sel_q, data_s;
  logic       rise, sel_fall;
  logic [7:0] rx_byte;

  assign sclk_s   = sclk_sync_q[1];
  assign sclk_q   = sclk_sync_q[2];
  assign sel_s    = sel_sync_q[1];
  assign sel_q    = sel_sync_q[2];
  assign data_s   = data_sync_q[1];
  assign rise     = sclk_s & ~sclk_q;
  assign sel_fall = ~sel_s & sel_q;
  // Byte completed by the bit arriving on this rise.
  assign rx_byte  = {shift_q, data_s};

`ifdef SPI_LOADER_MISO_EN
  logic       fall;
  logic [7:0] prev_cmd_d, prev_cmd_q;
  logic [7:0] miso_sr_d, miso_sr_q;

  assign fall         = ~sclk_s & sclk_q;
  assign spi.spi_miso = (state_q == S_CMD) ? miso_sr_q[7] : 1'b0;
`endif

  // Input synchroniser shift.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], spi.spi_clk};
    sel_sync_d  = {sel_sync_q[1:0],  spi.spi_sel_n};
    data_sync_d = {data_sync_q[0],   spi.spi_data};
  end

  // Next-state, datapath and output-pulse logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    target_bg_d   = target_bg_q;
    bg_shadow_d   = bg_shadow_q;
    fg_shadow_d   = fg_shadow_q;
    pending_d     = pending_q;
    bg_color_d    = bg_color_q;
    fg_color_d    = fg_color_q;
    sprite_load_d = 1'b0;
    sprite_data_d = 1'b0;
    load_done_d   = 1'b0;
    cmd_error_d   = 1'b0;
`ifdef SPI_LOADER_MISO_EN
    prev_cmd_d    = prev_cmd_q;
    miso_sr_d     = miso_sr_q;
`endif

    // Colour swap at frame boundary. A shadow write in this same cycle
    // re-arms pending below, so it lands at the following frame.
    if (next_frame && pending_q) begin
      bg_color_d = bg_shadow_q;
      fg_color_d = fg_shadow_q;
      pending_d  = 1'b0;
    end

    if (sel_s) begin
      // Chip select high wins over any simultaneous clock rise.
      if (state_q == S_LOAD && cnt_q != '0) cmd_error_d = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_fall) begin
            state_d = S_CMD;
            cnt_d   = '0;
`ifdef SPI_LOADER_MISO_EN
            miso_sr_d = prev_cmd_q;
`endif
          end
        end
        S_CMD: begin
`ifdef SPI_LOADER_MISO_EN
          if (fall) miso_sr_d = {miso_sr_q[6:0], 1'b0};
`endif
          if (rise) begin
            shift_d = rx_byte[6:0];
            if (cnt_q == BYTE_LAST) begin
              cnt_d = '0;
`ifdef SPI_LOADER_MISO_EN
              prev_cmd_d = rx_byte;
`endif
              case (rx_byte)
                CMD_LOAD: state_d = S_LOAD;
                CMD_BG:   begin state_d = S_ARG; target_bg_d = 1'b1; end
                CMD_FG:   begin state_d = S_ARG; target_bg_d = 1'b0; end
                default:  begin state_d = S_DISCARD; cmd_error_d = 1'b1; end
              endcase
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (rise) begin
            sprite_load_d = 1'b1;
            sprite_data_d = data_s;
            if (cnt_q == SPRITE_LAST) begin
              load_done_d = 1'b1;
              state_d     = S_DISCARD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_ARG: begin
          if (rise) begin
            shift_d = rx_byte[6:0];
            if (cnt_q == BYTE_LAST) begin
              if (target_bg_q) bg_shadow_d = rx_byte[5:0];
              else             fg_shadow_d = rx_byte[5:0];
              pending_d = 1'b1;
              state_d   = S_DISCARD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_DISCARD: ;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Select chain clears to 0 so a CS window cut by reset is never
      // mistaken for a new falling edge; it must go high first.
      sclk_sync_q   <= '0;
      sel_sync_q    <= '0;
      data_sync_q   <= '0;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      target_bg_q   <= 1'b0;
      bg_shadow_q   <= BG_RESET;
      fg_shadow_q   <= FG_RESET;
      pending_q     <= 1'b0;
      bg_color_q    <= BG_RESET;
      fg_color_q    <= FG_RESET;
      sprite_load_q <= 1'b0;
      sprite_data_q <= 1'b0;
      load_done_q   <= 1'b0;
      cmd_error_q   <= 1'b0;
`ifdef SPI_LOADER_MISO_EN
      prev_cmd_q    <= 8'h00;
      miso_sr_q     <= 8'h00;
`endif
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      sel_sync_q    <= sel_sync_d;
      data_sync_q   <= data_sync_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      target_bg_q   <= target_bg_d;
      bg_shadow_q   <= bg_shadow_d;
      fg_shadow_q   <= fg_shadow_d;
      pending_q     <= pending_d;
      bg_color_q    <= bg_color_d;
      fg_color_q    <= fg_color_d;
      sprite_load_q <= sprite_load_d;
      sprite_data_q <= sprite_data_d;
      load_done_q   <= load_done_d;
      cmd_error_q   <= cmd_error_d;
`ifdef SPI_LOADER_MISO_EN
      prev_cmd_q    <= prev_cmd_d;
      miso_sr_q     <= miso_sr_d;
`endif
    end
  end

  assign sprite_load = sprite_load_q;
  assign sprite_data = sprite_data_q;
  assign load_done   = load_done_q;
  assign cmd_error   = cmd_error_q;
  assign bg_color    = bg_color_q;
  assign fg_color    = fg_color_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_sprite_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_sprite_loader
// Purpose  : Self-checking bench for spi_sprite_loader with a transaction-level
//            reference model (bit queues, colour shadow/active bookkeeping).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_sprite_loader;
  localparam int NBITS = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       next_frame;
  logic       sprite_load, sprite_data, load_done, cmd_error;
  logic [5:0] bg_color, fg_color;

  spi_sprite_loader_if spi_if ();

  spi_sprite_loader dut (
    .clk         (clk),
    .reset       (reset),
    .spi         (spi_if),
    .next_frame  (next_frame),
    .sprite_load (sprite_load),
    .sprite_data (sprite_data),
    .load_done   (load_done),
    .cmd_error   (cmd_error),
    .bg_color    (bg_color),
    .fg_color    (fg_color)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [5:0] m_bg, m_fg, m_bg_sh, m_fg_sh;
  bit         m_pend;
  logic [7:0] m_prev_cmd;

  // Output monitor.
  int   n_load, n_done, n_err, done_at, done_alone, pulse_bad;
  logic prev_load, prev_done, prev_err;
  logic got_bits[$];
  logic sent[$];
  int   half = 4;

  always @(negedge clk) begin
    if (sprite_load) begin n_load++; got_bits.push_back(sprite_data); end
    if (load_done) begin
      n_done++; done_at = n_load;
      if (!sprite_load) done_alone++;
    end
    if (cmd_error) n_err++;
    if ((sprite_load && prev_load) || (load_done && prev_done) || (cmd_error && prev_err)) pulse_bad++;
    prev_load = sprite_load; prev_done = load_done; prev_err = cmd_error;
  end

  task automatic clear_mon();
    n_load = 0; n_done = 0; n_err = 0; done_at = -1; done_alone = 0;
    got_bits.delete(); sent.delete();
  endtask

  task automatic model_reset();
    m_bg = 6'h15; m_fg = 6'h3F; m_bg_sh = 6'h15; m_fg_sh = 6'h3F; m_pend = 0; m_prev_cmd = 8'h00;
  endtask

  task automatic spi_bit(input logic b);
    spi_if.spi_data = b;
    repeat (half) @(negedge clk);
    spi_if.spi_clk = 1'b1;
    repeat (half) @(negedge clk);
    spi_if.spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic cs_low();
    spi_if.spi_data = 1'b0;
    spi_if.spi_sel_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    spi_if.spi_sel_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_strobe();
    next_frame = 1'b1;
    @(negedge clk);
    next_frame = 1'b0;
    if (m_pend) begin m_bg = m_bg_sh; m_fg = m_fg_sh; m_pend = 0; end
    @(negedge clk);
  endtask

  // Load command followed by n bitmap bits; pattern 0 alternates 1,0..., else random.
  task automatic send_load(input int n, input int pattern);
    logic b;
    cs_low();
    spi_byte(8'h01);
    m_prev_cmd = 8'h01;
    for (int i = 0; i < n; i++) begin
      b = (pattern == 0) ? ~i[0] : 1'($urandom);
      sent.push_back(b);
      spi_bit(b);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    checks++; if (bg_color !== 6'h15) begin errors++; $display("FAIL reset_bg actual=%h expected=15", bg_color); end
    checks++; if (fg_color !== 6'h3F) begin errors++; $display("FAIL reset_fg actual=%h expected=3f", fg_color); end
    checks++; if ({sprite_load, load_done, cmd_error, sprite_data} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses actual=%b expected=0000", {sprite_load, load_done, cmd_error, sprite_data});
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_load(input int n, input int pattern, input string tag);
    int exp_n, mm;
    clear_mon();
    send_load(n, pattern);
    cs_high();
    exp_n = (n < NBITS) ? n : NBITS;
    mm = 0;
    for (int i = 0; i < exp_n && i < got_bits.size(); i++) if (got_bits[i] !== sent[i]) mm++;
    checks++; if (n_load !== exp_n) begin errors++; $display("FAIL %s_count actual=%0d expected=%0d", tag, n_load, exp_n); end
    checks++; if (mm !== 0) begin errors++; $display("FAIL %s_data mismatched_bits=%0d expected=0", tag, mm); end
    checks++; if (n_done !== ((n >= NBITS) ? 1 : 0)) begin
      errors++; $display("FAIL %s_done actual=%0d expected=%0d", tag, n_done, (n >= NBITS) ? 1 : 0);
    end
    if (n >= NBITS) begin
      checks++; if (done_at !== NBITS || done_alone !== 0) begin
        errors++; $display("FAIL %s_done_align actual_at=%0d alone=%0d expected_at=%0d", tag, done_at, done_alone, NBITS);
      end
    end
    checks++; if (n_err !== ((n > 0 && n < NBITS) ? 1 : 0)) begin
      errors++; $display("FAIL %s_err actual=%0d expected=%0d", tag, n_err, (n > 0 && n < NBITS) ? 1 : 0);
    end
  endtask

  task automatic test_colour(input logic [7:0] cmd);
    logic [7:0] arg;
    arg = 8'($urandom);
    clear_mon();
    cs_low();
    spi_byte(cmd);
    spi_byte(arg);
    cs_high();
    m_prev_cmd = cmd;
    if (cmd == 8'h02) m_bg_sh = arg[5:0]; else m_fg_sh = arg[5:0];
    m_pend = 1;
    checks++; if (bg_color !== m_bg || fg_color !== m_fg) begin
      errors++; $display("FAIL colour_hold cmd=%h actual=%h/%h expected=%h/%h", cmd, bg_color, fg_color, m_bg, m_fg);
    end
    frame_strobe();
    checks++; if (bg_color !== m_bg || fg_color !== m_fg) begin
      errors++; $display("FAIL colour_apply cmd=%h actual=%h/%h expected=%h/%h", cmd, bg_color, fg_color, m_bg, m_fg);
    end
    checks++; if (n_err !== 0 || n_load !== 0) begin
      errors++; $display("FAIL colour_side actual_err=%0d loads=%0d expected=0/0", n_err, n_load);
    end
  endtask

  task automatic test_short_arg();
    clear_mon();
    cs_low();
    spi_byte(8'h02);
    m_prev_cmd = 8'h02;
    for (int i = 0; i < 5; i++) spi_bit(1'b1);
    cs_high();
    frame_strobe();
    checks++; if (bg_color !== m_bg || n_err !== 0) begin
      errors++; $display("FAIL short_arg actual_bg=%h err=%0d expected_bg=%h err=0", bg_color, n_err, m_bg);
    end
  endtask

  task automatic test_unknown();
    logic [7:0] cmd;
    cmd = 8'($urandom);
    if (cmd >= 8'h01 && cmd <= 8'h03) cmd = cmd ^ 8'h80;
    clear_mon();
    cs_low();
    spi_byte(cmd);
    m_prev_cmd = cmd;
    spi_byte(8'($urandom));
    spi_byte(8'($urandom));
    cs_high();
    frame_strobe();
    checks++; if (n_err !== 1) begin errors++; $display("FAIL unknown_err cmd=%h actual=%0d expected=1", cmd, n_err); end
    checks++; if (n_load !== 0 || n_done !== 0) begin
      errors++; $display("FAIL unknown_load actual=%0d/%0d expected=0/0", n_load, n_done);
    end
    checks++; if (bg_color !== m_bg || fg_color !== m_fg) begin
      errors++; $display("FAIL unknown_colour actual=%h/%h expected=%h/%h", bg_color, fg_color, m_bg, m_fg);
    end
  endtask

  task automatic test_reset_mid_load();
    clear_mon();
    send_load(40, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    clear_mon();
    for (int i = 0; i < 20; i++) spi_bit(1'($urandom));
    cs_high();
    checks++; if (n_load !== 0 || n_done !== 0 || n_err !== 0) begin
      errors++; $display("FAIL reset_mid_load actual=%0d/%0d/%0d expected=0/0/0", n_load, n_done, n_err);
    end
    checks++; if (bg_color !== m_bg || fg_color !== m_fg) begin
      errors++; $display("FAIL reset_mid_colour actual=%h/%h expected=%h/%h", bg_color, fg_color, m_bg, m_fg);
    end
  endtask

`ifdef SPI_LOADER_MISO_EN
  task automatic test_miso();
    logic [7:0] got;
    clear_mon();
    checks++; if (spi_if.spi_miso !== 1'b0) begin errors++; $display("FAIL miso_idle actual=%b expected=0", spi_if.spi_miso); end
    cs_low();
    got = '0;
    for (int i = 7; i >= 0; i--) begin
      spi_if.spi_data = (i == 1) ? 1'b1 : 1'b0;
      repeat (half) @(negedge clk);
      got[i] = spi_if.spi_miso;
      spi_if.spi_clk = 1'b1;
      repeat (half) @(negedge clk);
      spi_if.spi_clk = 1'b0;
    end
    spi_byte(8'h00);
    cs_high();
    checks++; if (got !== m_prev_cmd) begin errors++; $display("FAIL miso_echo actual=%h expected=%h", got, m_prev_cmd); end
    m_prev_cmd = 8'h02;
    m_bg_sh = 6'h00; m_pend = 1;
  endtask
`endif

  initial begin
    reset = 1'b1; next_frame = 1'b0;
    spi_if.spi_clk = 1'b0; spi_if.spi_data = 1'b0; spi_if.spi_sel_n = 1'b1;
    pulse_bad = 0; prev_load = 0; prev_done = 0; prev_err = 0;
    clear_mon();
    model_reset();
    test_reset();
    test_load(NBITS, 0, "load_alt");
    test_load(NBITS, 1, "load_rand");
    test_load(37, 1, "trunc37");
    test_load($urandom_range(1, NBITS - 1), 1, "trunc_rand");
    test_load(0, 1, "empty_load");
    test_load(110, 1, "overrun");
    test_colour(8'h02);
    test_colour(8'h03);
    test_short_arg();
    test_unknown();
    half = 2;
    test_load(NBITS, 1, "fast_load");
    test_colour(8'h02);
    half = 4;
    test_reset_mid_load();
    test_load(NBITS, 1, "after_reset");
`ifdef SPI_LOADER_MISO_EN
    test_miso();
`endif
    checks++; if (pulse_bad !== 0) begin errors++; $display("FAIL pulse_width actual=%0d expected=0", pulse_bad); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
